// File: rtl/typedef_pkg.sv
// Shared types for the vector instruction queue: the stored entry layout,
// the "no instruction" encoding and the push/pop operation classifier.
package typedef_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;
  localparam int SEW_W   = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [SEW_W-1:0]   sew;
  } v_instr_entry_t;

  localparam logic [INSTR_W-1:0] V_INSTR_NOP = 32'h0;

  // What the head shows when nothing is available: the scheduler decodes it as "no instruction".
  localparam v_instr_entry_t V_ENTRY_EMPTY = '{instr: V_INSTR_NOP, default: '0};

  // Encoding is {push, pop} so the cast in q_op() is direct.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/v_queue_ptr.sv
// Wrap-around pointer register for the instruction queue. The width matches
// a power-of-two depth, so natural overflow implements the wrap.
module v_queue_ptr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/v_instr_queue.sv
// Decoupling FIFO between the scalar core's vector issue port and the vector
// scheduler. Define V_QUEUE_BYPASS_EN to let an empty queue forward the input.
module v_instr_queue
  import typedef_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         instr_vld_i,
  input  logic [31:0]  vector_instr_i,
  input  logic [31:0]  rs1_i,
  input  logic [31:0]  rs2_i,
  input  logic [1:0]   sew_i,
  output logic         vector_stall_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [31:0]  vector_instr_o,
  output logic [31:0]  rs1_o,
  output logic [31:0]  rs2_o,
  output logic [1:0]   sew_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  v_instr_entry_t        r_mem [DEPTH];
  logic [PTR_W:0]        r_count;
  logic [PTR_W-1:0]      w_wr_ptr;
  logic [PTR_W-1:0]      w_rd_ptr;

  v_instr_entry_t        w_in_entry;
  v_instr_entry_t        w_head;
  logic                  w_out_vld;
  logic                  w_clr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass_take;

  assign w_in_entry = '{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i, sew: sew_i};

  // Reset is treated exactly like a flush, including its effect on stall and bypass.
  assign w_clr   = rst || flush_i;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef V_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = w_empty && instr_vld_i && !w_clr;
  assign w_bypass_take = w_bypass && out_rdy_i;
`else
  assign w_bypass_take = 1'b0;
`endif

  // A full queue rejects the offer even when a pop frees a slot on the same edge.
  assign w_push = instr_vld_i && !w_full && !w_clr && !w_bypass_take;
  assign w_pop  = !w_empty && out_rdy_i && !w_clr;

  assign vector_stall_o = instr_vld_i && w_full && !w_clr;

  v_queue_ptr #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push),
    .i_clr (flush_i),
    .o_ptr (w_wr_ptr)
  );

  v_queue_ptr #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop),
    .i_clr (flush_i),
    .o_ptr (w_rd_ptr)
  );

  // NOTE: the storage array has no reset; occupancy is tracked by r_count, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_count <= '0;
    end else begin
      case (q_op(w_push, w_pop))
        Q_PUSH:  r_count <= r_count + (PTR_W + 1)'(1);
        Q_POP:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_head    = V_ENTRY_EMPTY;
    w_out_vld = 1'b0;
    if (!w_empty) begin
      w_head    = r_mem[w_rd_ptr];
      w_out_vld = 1'b1;
    end
`ifdef V_QUEUE_BYPASS_EN
    if (w_bypass) begin
      w_head    = w_in_entry;
      w_out_vld = 1'b1;
    end
`endif
  end

  assign out_vld_o      = w_out_vld;
  assign vector_instr_o = w_head.instr;
  assign rs1_o          = w_head.rs1;
  assign rs2_o          = w_head.rs2;
  assign sew_o          = w_head.sew;
  assign count_o        = r_count;

endmodule

// File: tb/tb_v_instr_queue.sv
// Self-checking bench for v_instr_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_v_instr_queue;
  import typedef_pkg::*;

  localparam int DEPTH = 4;
`ifdef V_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        instr_vld_i;
  logic [31:0] vector_instr_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [1:0]  sew_i;
  logic        vector_stall_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic [31:0] vector_instr_o;
  logic [31:0] rs1_o;
  logic [31:0] rs2_o;
  logic [1:0]  sew_o;
  logic [2:0]  count_o;

  v_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .instr_vld_i    (instr_vld_i),
    .vector_instr_i (vector_instr_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .sew_i          (sew_i),
    .vector_stall_o (vector_stall_o),
    .out_vld_o      (out_vld_o),
    .out_rdy_i      (out_rdy_i),
    .vector_instr_o (vector_instr_o),
    .rs1_o          (rs1_o),
    .rs2_o          (rs2_o),
    .sew_o          (sew_o),
    .count_o        (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the queue contents in arrival order.
  v_instr_entry_t q[$];
  bit m_pop, m_push, m_byp;

  always @(posedge clk) begin
    if (rst || flush_i) begin
      q.delete();
    end else begin
      m_pop  = (q.size() != 0) && out_rdy_i;
      m_byp  = BYPASS && (q.size() == 0) && instr_vld_i && out_rdy_i;
      m_push = instr_vld_i && (q.size() < DEPTH) && !m_byp;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back('{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i, sew: sew_i});
    end
  end

  v_instr_entry_t e_head;
  logic           e_vld;
  logic           e_stall;

  always @(negedge clk) begin
    if (chk_en) begin
      e_head = '0;
      e_vld  = 1'b0;
      if (q.size() != 0) begin
        e_head = q[0];
        e_vld  = 1'b1;
      end else if (BYPASS && instr_vld_i && !rst && !flush_i) begin
        e_head = '{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i, sew: sew_i};
        e_vld  = 1'b1;
      end
      e_stall = instr_vld_i && (q.size() == DEPTH) && !rst && !flush_i;
      check("cmp_vld",   32'(out_vld_o),      32'(e_vld));
      check("cmp_instr", vector_instr_o,      e_head.instr);
      check("cmp_rs1",   rs1_o,               e_head.rs1);
      check("cmp_rs2",   rs2_o,               e_head.rs2);
      check("cmp_sew",   32'(sew_o),          32'(e_head.sew));
      check("cmp_count", 32'(count_o),        32'(q.size()));
      check("cmp_stall", 32'(vector_stall_o), 32'(e_stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] ins, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [1:0] s);
    instr_vld_i    = 1'b1;
    vector_instr_i = ins;
    rs1_i          = r1;
    rs2_i          = r2;
    sew_i          = s;
    tick();
    instr_vld_i = 1'b0;
  endtask

  task automatic drain();
    out_rdy_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    out_rdy_i = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; instr_vld_i = 1'b0; out_rdy_i = 1'b0;
    vector_instr_i = '0; rs1_i = '0; rs2_i = '0; sew_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_en = 1'b1;

    // Reset state
    check("rst_vld",   32'(out_vld_o), 32'd0);
    check("rst_instr", vector_instr_o, 32'd0);
    check("rst_rs1",   rs1_o,          32'd0);
    check("rst_rs2",   rs2_o,          32'd0);
    check("rst_sew",   32'(sew_o),     32'd0);
    check("rst_count", 32'(count_o),   32'd0);
    check("rst_stall", 32'(vector_stall_o), 32'd0);

    // Single push, visible after the edge
    push_entry(32'h0200_7007, 32'h1000, 32'd4, 2'd2);
    #1;
    check("p1_vld",   32'(out_vld_o), 32'd1);
    check("p1_instr", vector_instr_o, 32'h0200_7007);
    check("p1_rs1",   rs1_o,          32'h1000);
    check("p1_rs2",   rs2_o,          32'd4);
    check("p1_sew",   32'(sew_o),     32'd2);
    check("p1_count", 32'(count_o),   32'd1);
    drain();

    // Fill, stall on a fifth offer, pop frees a slot but the same-edge push is refused
    for (int k = 1; k <= 4; k++) push_entry(32'(k), 32'(k + 16), 32'(k + 32), 2'(k));
    check("full_count", 32'(count_o), 32'd4);
    instr_vld_i = 1'b1; vector_instr_i = 32'd5; rs1_i = 32'd21; rs2_i = 32'd37; sew_i = 2'd1;
    #1;
    check("full_stall", 32'(vector_stall_o), 32'd1);
    tick();
    check("full_hold_count", 32'(count_o), 32'd4);
    check("full_hold_head",  vector_instr_o, 32'd1);
    out_rdy_i = 1'b1;
    #1;
    check("stall_indep_rdy", 32'(vector_stall_o), 32'd1);
    tick();
    out_rdy_i = 1'b0;
    #1;
    check("after_pop_count", 32'(count_o), 32'd3);
    check("after_pop_stall", 32'(vector_stall_o), 32'd0);
    check("after_pop_head",  vector_instr_o, 32'd2);
    tick();
    instr_vld_i = 1'b0;
    #1;
    check("retry_count", 32'(count_o), 32'd4);
    out_rdy_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("order_head", vector_instr_o, 32'(k));
      tick();
    end
    out_rdy_i = 1'b0;
    #1;
    check("order_empty", 32'(count_o), 32'd0);

    // Steady-state push+pop across pointer wrap
    push_entry(32'd100, 32'd0, 32'd0, 2'd0);
    push_entry(32'd101, 32'd0, 32'd0, 2'd0);
    instr_vld_i = 1'b1; out_rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vector_instr_i = 32'(102 + i);
      rs1_i          = 32'(i);
      #1;
      check("wrap_head",  vector_instr_o, 32'(100 + i));
      check("wrap_count", 32'(count_o),   32'd2);
      tick();
    end
    instr_vld_i = 1'b0;
    drain();

    // Flush beats a simultaneous push and pop
    for (int k = 0; k < 3; k++) push_entry(32'(32'h200 + k), 32'd1, 32'd2, 2'd3);
    flush_i = 1'b1; instr_vld_i = 1'b1; vector_instr_i = 32'hDEAD_BEEF; out_rdy_i = 1'b1;
    #1;
    check("flush_stall", 32'(vector_stall_o), 32'd0);
    tick();
    flush_i = 1'b0; instr_vld_i = 1'b0; out_rdy_i = 1'b0;
    #1;
    check("flush_count", 32'(count_o),   32'd0);
    check("flush_vld",   32'(out_vld_o), 32'd0);
    check("flush_instr", vector_instr_o, 32'd0);

    // Flush while full and offering: no stall in that cycle
    for (int k = 0; k < 4; k++) push_entry(32'(32'h300 + k), 32'd0, 32'd0, 2'd0);
    instr_vld_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush_full_stall", 32'(vector_stall_o), 32'd0);
    tick();
    instr_vld_i = 1'b0; flush_i = 1'b0;

    // Ready on an empty queue does nothing
    out_rdy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_rdy_count", 32'(count_o), 32'd0);
      check("empty_rdy_instr", vector_instr_o, 32'd0);
    end
    out_rdy_i = 1'b0;
    push_entry(32'h0000_0777, 32'd7, 32'd8, 2'd1);
    #1;
    check("after_idle_head", vector_instr_o, 32'h0000_0777);
    drain();

    // Bypass behaviour (or its absence) on an empty queue
    instr_vld_i = 1'b1; vector_instr_i = 32'h0000_0057; rs1_i = 32'd9; rs2_i = 32'd10; sew_i = 2'd0;
    out_rdy_i = 1'b1;
    #1;
    if (BYPASS) begin
      check("byp_same_instr", vector_instr_o, 32'h0000_0057);
      check("byp_same_vld",   32'(out_vld_o), 32'd1);
    end else begin
      check("nobyp_same_instr", vector_instr_o, 32'd0);
      check("nobyp_same_vld",   32'(out_vld_o), 32'd0);
    end
    check("byp_same_count", 32'(count_o), 32'd0);
    tick();
    instr_vld_i = 1'b0; out_rdy_i = 1'b0;
    #1;
    if (BYPASS) begin
      check("byp_next_count", 32'(count_o), 32'd0);
    end else begin
      check("nobyp_next_count", 32'(count_o), 32'd1);
      check("nobyp_next_instr", vector_instr_o, 32'h0000_0057);
    end
    drain();

    // Reset in the middle of operation
    push_entry(32'h0000_0A01, 32'd1, 32'd1, 2'd1);
    push_entry(32'h0000_0A02, 32'd2, 32'd2, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_vld",   32'(out_vld_o), 32'd0);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
